noc_vc_merge_arb: RTL



---
 rtl/noc_vc_merge_arb_pkg.sv | 20 ++
 rtl/noc_vc_merge_arb_if.sv | 37 +++
 rtl/noc_vc_merge_arb_rr_arbiter.sv | 32 +++
 rtl/noc_vc_merge_arb.sv | 133 +++++++++++++
 4 files changed

// File: rtl/noc_vc_merge_arb_pkg.sv
// Shared defaults and types for the NoC VC merge stage.
package Noc_parameters;

    localparam int Noc_VC_Channel    = 4;
    localparam int Noc_Data_Width    = 32;
    localparam int Noc_VC_Fifo_Depth = 8;
    localparam int Noc_VC_Idx_W      = $clog2(Noc_VC_Channel);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } noc_vc_merge_state_e;

    typedef struct packed {
        logic [Noc_Data_Width-1:0] flit;
        logic [Noc_VC_Idx_W-1:0]   vc;
        logic                      last;
    } noc_vc_fifo_entry_t;

endpackage

// File: rtl/noc_vc_merge_arb_if.sv
// Handshake bundle between upstream VCs, the merge stage and the downstream consumer.
interface noc_vc_merge_arb_if
    import Noc_parameters::*;
#(
    parameter int CHANNELS = Noc_VC_Channel,
    parameter int DATA_W   = Noc_Data_Width,
    parameter int DEPTH    = Noc_VC_Fifo_Depth
);
    localparam int VC_W  = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CHANNELS-1:0]             in_valid;
    logic [CHANNELS-1:0]             in_last;
    logic [CHANNELS-1:0][DATA_W-1:0] in_flit;
    logic [CHANNELS-1:0]             in_ready;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_W-1:0]               out_flit;
    logic [VC_W-1:0]                 out_vc;
    logic                            out_last;
    logic                            almost_full;
    logic [CNT_W-1:0]                count;
    logic [CHANNELS-1:0][15:0]       perf_cnt;

    modport master (
        output in_valid, in_last, in_flit, out_ready,
        input  in_ready, out_valid, out_flit, out_vc, out_last,
               almost_full, count, perf_cnt
    );

    modport slave (
        input  in_valid, in_last, in_flit, out_ready,
        output in_ready, out_valid, out_flit, out_vc, out_last,
               almost_full, count, perf_cnt
    );

endinterface

// File: rtl/noc_vc_merge_arb_rr_arbiter.sv
// Round-robin priority pick: first requester at or after rr_ptr, wrapping upward.
module noc_rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int VC_W     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [VC_W-1:0]     rr_ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [VC_W-1:0]     grant_idx
);

    always_comb begin
        int          j;
        logic        found;
        logic [VC_W-1:0] jv;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        jv        = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            j  = (int'(rr_ptr) + k) % CHANNELS;
            jv = j[VC_W-1:0];
            if (!found && req[jv]) begin
                found     = 1'b1;
                grant[jv] = 1'b1;
                grant_idx = jv;
            end
        end
    end

endmodule

// File: rtl/noc_vc_merge_arb.sv
// VC merge with wormhole-locked round-robin arbitration into a FWFT FIFO.
// Optional per-VC saturating push counters under NOC_VC_MERGE_PERF_EN.
module noc_vc_merge_arb
    import Noc_parameters::*;
#(
    parameter int CHANNELS  = Noc_VC_Channel,
    parameter int DATA_W    = Noc_Data_Width,
    parameter int DEPTH     = Noc_VC_Fifo_Depth,
    parameter int THRESHOLD = DEPTH - 2
) (
    input  logic             noc_clk,
    input  logic             noc_rst,
    noc_vc_merge_arb_if.slave bus
);

    localparam int VC_W  = $clog2(CHANNELS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Same layout as noc_vc_fifo_entry_t, sized for this instance.
    typedef struct packed {
        logic [DATA_W-1:0] flit;
        logic [VC_W-1:0]   vc;
        logic              last;
    } entry_t;

    noc_vc_merge_state_e state;
    logic [VC_W-1:0]     owner;
    logic [VC_W-1:0]     rr_ptr;

    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] gnt;
    logic [VC_W-1:0]     gnt_idx;
    logic [VC_W-1:0]     nxt_ptr;
    logic                push, pop, push_last;
    logic                full, empty;

    entry_t              mem [DEPTH];
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count_q;

    // While a packet is in flight only its owner may compete.
    always_comb begin
        req = bus.in_valid;
        if (state == LOCKED) req = bus.in_valid & (CHANNELS'(1) << owner);
    end

    noc_rr_arbiter #(.CHANNELS(CHANNELS), .VC_W(VC_W)) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign bus.in_ready = (full || noc_rst) ? '0 : gnt;
    assign push         = |(bus.in_valid & bus.in_ready);
    assign push_last    = bus.in_last[gnt_idx];
    assign pop          = bus.out_valid && bus.out_ready;
    assign nxt_ptr      = (gnt_idx == VC_W'(CHANNELS - 1)) ? '0 : gnt_idx + VC_W'(1);

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (push) begin
            case (state)
                IDLE: begin
                    if (!push_last) begin
                        state <= LOCKED;
                        owner <= gnt_idx;
                    end else begin
                        rr_ptr <= nxt_ptr;
                    end
                end
                LOCKED: begin
                    if (push_last) begin
                        state  <= IDLE;
                        rr_ptr <= nxt_ptr;
                    end
                end
            endcase
        end
    end

    // Storage carries no reset; empty gating keeps outputs defined.
    always_ff @(posedge noc_clk) begin
        if (push) mem[wr_ptr] <= '{flit: bus.in_flit[gnt_idx], vc: gnt_idx, last: push_last};
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign full            = (count_q == CNT_W'(DEPTH));
    assign empty           = (count_q == '0);
    assign head            = mem[rd_ptr];
    assign bus.out_valid   = !empty;
    assign bus.out_flit    = empty ? '0 : head.flit;
    assign bus.out_vc      = empty ? '0 : head.vc;
    assign bus.out_last    = empty ? 1'b0 : head.last;
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= CNT_W'(THRESHOLD));

`ifdef NOC_VC_MERGE_PERF_EN
    logic [CHANNELS-1:0][15:0] perf_q;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_perf
        always_ff @(posedge noc_clk or posedge noc_rst) begin
            if (noc_rst)
                perf_q[i] <= '0;
            else if (bus.in_valid[i] && bus.in_ready[i] && perf_q[i] != 16'hFFFF)
                perf_q[i] <= perf_q[i] + 16'd1;
        end
    end
    assign bus.perf_cnt = perf_q;
`else
    assign bus.perf_cnt = '0;
`endif

endmodule
